// File: rtl/riscv_muldiv_seq_pkg.sv
// Shared RV32M multiply/divide definitions: funct3/funct7 encodings and sequencer states.
package muldiv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [2:0] F3_MUL     = 3'b000;
    localparam logic [2:0] F3_MULH    = 3'b001;
    localparam logic [2:0] F3_MULHSU  = 3'b010;
    localparam logic [2:0] F3_MULHU   = 3'b011;
    localparam logic [2:0] F3_DIV     = 3'b100;
    localparam logic [2:0] F3_DIVU    = 3'b101;
    localparam logic [2:0] F3_REM     = 3'b110;
    localparam logic [2:0] F3_REMU    = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } muldiv_state_e;

endpackage

// File: rtl/riscv_muldiv_seq_if.sv
// Execute-stage request/response bundle between the pipeline and the mul/div sequencer.
interface riscv_muldiv_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            stall;
    logic            busy;
    logic [XLEN-1:0] result;
    logic            result_valid;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  stall, busy, result, result_valid
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output stall, busy, result, result_valid
    );
endinterface

// File: rtl/riscv_muldiv_seq_div_step.sv
// One restoring-division step on magnitudes: shift in the next dividend bit, subtract if it fits.
module muldiv_div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quot,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quot_next
);
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    assign rem_sh = {rem, quot[XLEN-1]};
    assign diff   = rem_sh - {1'b0, divisor};

    // A clear borrow bit means the shifted remainder was >= divisor.
    always_comb begin
        if (!diff[XLEN]) begin
            rem_next  = diff[XLEN-1:0];
            quot_next = {quot[XLEN-2:0], 1'b1};
        end else begin
            rem_next  = rem_sh[XLEN-1:0];
            quot_next = {quot[XLEN-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/riscv_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the execute stage.
// Build option MULDIV_FAST_MUL_EN: multiplies complete in one cycle through a full-width product.
module riscv_muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    riscv_muldiv_seq_if.slave    bus
);
    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam int unsigned PW    = 2 * XLEN;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e    state_q, state_d;
    logic [2:0]       f3_q;
    logic             neg_q;
    logic             rneg_q;
    logic [XLEN-1:0]  acc_hi_q;
    logic [XLEN-1:0]  acc_lo_q;
    logic [XLEN-1:0]  opb_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  result_q;
    logic             valid_q;

    logic             load_op;
    logic             iterate;
    logic             load_res;
    logic [XLEN-1:0]  res_d;
    logic             stall_c;

    function automatic logic [XLEN-1:0] mul_pick(input logic [2:0] f3, input logic neg,
                                                 input logic [PW-1:0] prod);
        logic [PW-1:0] p;
        p = neg ? -prod : prod;
        return (f3 == F3_MUL) ? p[XLEN-1:0] : p[PW-1:XLEN];
    endfunction

    // Incoming-op decode: signedness, magnitudes and the early-exit divide cases.
    logic            is_div_in;
    logic            a_signed_in;
    logic            b_signed_in;
    logic            sa_in;
    logic            sb_in;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic            fast_in;
    logic [XLEN-1:0] fast_val;

    assign is_div_in   = bus.funct3[2];
    assign a_signed_in = is_div_in ? !bus.funct3[0] : (bus.funct3 != F3_MULHU);
    assign b_signed_in = is_div_in ? !bus.funct3[0]
                                   : (bus.funct3 == F3_MUL || bus.funct3 == F3_MULH);
    assign sa_in       = a_signed_in && bus.op_a[XLEN-1];
    assign sb_in       = b_signed_in && bus.op_b[XLEN-1];
    assign a_mag       = sa_in ? -bus.op_a : bus.op_a;
    assign b_mag       = sb_in ? -bus.op_b : bus.op_b;
    assign div_zero    = is_div_in && (bus.op_b == '0);
    assign div_ovf     = is_div_in && b_signed_in && (bus.op_a == INT_MIN) && (bus.op_b == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic [PW-1:0] prod_in;
    assign prod_in = PW'(a_mag) * PW'(b_mag);
    assign fast_in = div_zero || div_ovf || !is_div_in;
`else
    assign fast_in = div_zero || div_ovf;
`endif

    always_comb begin
        fast_val = '0;
        if (div_zero) begin
            fast_val = bus.funct3[1] ? bus.op_a : '1;
        end else if (div_ovf) begin
            fast_val = bus.funct3[1] ? '0 : INT_MIN;
        end
`ifdef MULDIV_FAST_MUL_EN
        else begin
            fast_val = mul_pick(bus.funct3, sa_in ^ sb_in, prod_in);
        end
`endif
    end

    // Iteration datapath: shift-add multiply and shared restoring divide step.
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] div_rem_nx;
    logic [XLEN-1:0] div_quot_nx;
    logic [XLEN-1:0] hi_nx;
    logic [XLEN-1:0] lo_nx;
    logic [XLEN-1:0] final_val;
    logic            cnt_last;

    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);

    muldiv_div_step #(.XLEN(XLEN)) u_div_step (
        .rem       (acc_hi_q),
        .quot      (acc_lo_q),
        .divisor   (opb_q),
        .rem_next  (div_rem_nx),
        .quot_next (div_quot_nx)
    );

    assign hi_nx = f3_q[2] ? div_rem_nx  : mul_sum[XLEN:1];
    assign lo_nx = f3_q[2] ? div_quot_nx : {mul_sum[0], acc_lo_q[XLEN-1:1]};

    // Sign correction applied to the post-step values so the result is ready in DONE.
    always_comb begin
        if (f3_q[2]) begin
            if (f3_q[1]) final_val = rneg_q ? -hi_nx : hi_nx;
            else         final_val = neg_q  ? -lo_nx : lo_nx;
        end else begin
            final_val = mul_pick(f3_q, neg_q, {hi_nx, lo_nx});
        end
    end

    assign cnt_last = (cnt_q == CNT_W'(XLEN - 1));

    always_comb begin
        state_d  = state_q;
        load_op  = 1'b0;
        iterate  = 1'b0;
        load_res = 1'b0;
        res_d    = result_q;
        stall_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    stall_c = 1'b1;
                    load_op = 1'b1;
                    if (fast_in) begin
                        state_d  = S_DONE;
                        load_res = 1'b1;
                        res_d    = fast_val;
                    end else begin
                        state_d  = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                stall_c = 1'b1;
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    iterate = 1'b1;
                    if (cnt_last) begin
                        state_d  = S_DONE;
                        load_res = 1'b1;
                        res_d    = final_val;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= load_res;
            if (load_res) result_q <= res_d;
            if (load_op) begin
                f3_q     <= bus.funct3;
                neg_q    <= sa_in ^ sb_in;
                rneg_q   <= sa_in;
                acc_hi_q <= '0;
                acc_lo_q <= a_mag;
                opb_q    <= b_mag;
                cnt_q    <= '0;
            end else if (iterate) begin
                acc_hi_q <= hi_nx;
                acc_lo_q <= lo_nx;
                cnt_q    <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Stall is combinational so the requesting instruction holds in EX; forced low in reset.
    assign bus.stall        = stall_c && !rst;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;

endmodule

// File: tb/tb_riscv_muldiv_seq.sv
// Directed self-checking bench for riscv_muldiv_seq: results, latency, stall window, flush and reset abort.
module tb_riscv_muldiv_seq;
    import muldiv_pkg::*;

    localparam int unsigned XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT  = XLEN + 1;
    localparam int FAST_LAT = 1;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] last_res;

    always #5 clk = ~clk;

    riscv_muldiv_seq_if #(.XLEN(XLEN)) bus ();

    riscv_muldiv_seq #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Holds start like a stalled EX stage; returns at the DONE cycle with start dropped.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                         input bit garble);
        int lat;
        int stall_cyc;
        bit got;
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        #1;
        stall_cyc = bus.stall ? 1 : 0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.result_valid) got = 1'b1;
            else if (bus.stall)   stall_cyc++;
            if (garble && lat == 1) begin
                bus.op_a   = 32'hDEAD_BEEF;
                bus.op_b   = 32'd3;
                bus.funct3 = F3_REMU;
            end
        end
        check_val({tag, "_stall_in_done"}, 64'(bus.stall), 64'd0);
        bus.start = 1'b0;
        check_val({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "_result"}, 64'(bus.result), 64'(exp_res));
        check_val({tag, "_stall_cycles"}, 64'(stall_cyc), 64'(exp_lat));
        last_res = exp_res;
    endtask

    // Cycle right after DONE: pulse must be over and the result held.
    task automatic gap(input string tag);
        @(negedge clk);
        check_val({tag, "_valid_pulse"}, 64'(bus.result_valid), 64'd0);
        check_val({tag, "_held"}, 64'(bus.result), 64'(last_res));
        check_val({tag, "_idle"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int pulses;
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.flush  = 1'b0;
        bus.funct3 = F3_MUL;
        bus.op_a   = 32'd3;
        bus.op_b   = 32'd4;
        last_res   = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_stall_gated", 64'(bus.stall), 64'd0);
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        check_val("rst_valid", 64'(bus.result_valid), 64'd0);
        check_val("rst_result", 64'(bus.result), 64'd0);
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_busy", 64'(bus.busy), 64'd0);
        check_val("post_rst_stall", 64'(bus.stall), 64'd0);

        do_op("mul_7_m3",      F3_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 1'b0); gap("g1");
        do_op("mulh_min_min",  F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 1'b0); gap("g2");
        do_op("mulhu_ff_2",    F3_MULHU,  32'hFFFF_FFFF, 32'd2,         32'h0000_0001, MUL_LAT, 1'b0); gap("g3");
        do_op("mulhsu_m1_2",   F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, MUL_LAT, 1'b0); gap("g4");
        do_op("mul_6_7",       F3_MUL,    32'd6,         32'd7,         32'd42,        MUL_LAT, 1'b0); gap("g5");
        do_op("divu_5_0",      F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, FAST_LAT, 1'b0); gap("g6");
        do_op("remu_5_0",      F3_REMU,   32'd5,         32'd0,         32'd5,         FAST_LAT, 1'b0); gap("g7");
        do_op("div_ovf",       F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FAST_LAT, 1'b0); gap("g8");
        do_op("rem_ovf",       F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         FAST_LAT, 1'b0); gap("g9");
        do_op("div_m7_2",      F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT, 1'b0); gap("g10");
        do_op("rem_m7_2",      F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT, 1'b0); gap("g11");
        do_op("div_7_m2",      F3_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT, 1'b0); gap("g12");
        do_op("rem_7_m2",      F3_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         DIV_LAT, 1'b0); gap("g13");
        do_op("remu_100_7",    F3_REMU,   32'd100,       32'd7,         32'd2,         DIV_LAT, 1'b0); gap("g14");
        // Inputs change while busy; the latched op must still complete unchanged.
        do_op("divu_garble",   F3_DIVU,   32'd100,       32'd7,         32'd14,        DIV_LAT, 1'b1); gap("g15");

        // Flush at BUSY cycle 10.
        bus.start = 1'b1; bus.funct3 = F3_DIVU; bus.op_a = 32'd1000; bus.op_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check_val("flush_pre_busy", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check_val("flush_idle", 64'(bus.busy), 64'd0);
        check_val("flush_stall", 64'(bus.stall), 64'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.result_valid) pulses++;
        end
        check_val("flush_no_valid", 64'(pulses), 64'd0);
        check_val("flush_result_held", 64'(bus.result), 64'(last_res));

        // Reset at BUSY cycle 5.
        bus.start = 1'b1; bus.funct3 = F3_DIVU; bus.op_a = 32'd1000; bus.op_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check_val("rstmid_pre_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        bus.start = 1'b1;
        #1;
        check_val("rstmid_stall_gated", 64'(bus.stall), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        check_val("rstmid_idle", 64'(bus.busy), 64'd0);
        check_val("rstmid_stall", 64'(bus.stall), 64'd0);
        check_val("rstmid_result", 64'(bus.result), 64'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.result_valid) pulses++;
        end
        check_val("rstmid_no_valid", 64'(pulses), 64'd0);
        last_res = 32'd0;

        do_op("divu_after_rst", F3_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT, 1'b0); gap("g16");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
